// File: rtl/mp_cache_tag_pkg.sv
// Shared types and constants for the cache tag-lookup controller.
// Tag SRAM entry layout is {valid, tag}; one entry per set.
package mp_cache_tag_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int INDEX_WIDTH  = 4;
   localparam int OFFSET_WIDTH = 5;
   localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int ENTRY_WIDTH  = TAG_WIDTH + 1;

   // Request opcodes; RSVD behaves as LOOKUP.
   typedef enum logic [1:0] {
      LOOKUP = 2'b00,
      FILL   = 2'b01,
      INVAL  = 2'b10,
      RSVD   = 2'b11
   } tag_op_e;

   // Controller states.
   typedef enum logic [1:0] {
      INIT = 2'b00,
      IDLE = 2'b01,
      CMP  = 2'b10,
      WR   = 2'b11
   } tag_state_e;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
   } tag_entry_t;

   // True when the stored entry is valid and holds the requested tag.
   function automatic logic entry_hit(input tag_entry_t entry, input logic [TAG_WIDTH-1:0] tag);
      return entry.valid && (entry.tag == tag);
   endfunction

   // Entry written by a FILL (valid line) or an INVAL (all zero).
   function automatic tag_entry_t write_entry(input tag_op_e op, input logic [TAG_WIDTH-1:0] tag);
      tag_entry_t entry;
      entry.valid = 1'b0;
      entry.tag   = {TAG_WIDTH{1'b0}};
      if (op == FILL) begin
         entry.valid = 1'b1;
         entry.tag   = tag;
      end else begin
         entry.valid = 1'b0;
      end
      return entry;
   endfunction

endpackage

// File: rtl/mp_cache_tag_ctrl.sv
// Tag-lookup controller driving port 0 of the 16x24 single-port tag SRAM.
// After reset it sweeps every set to zero, then serves LOOKUP / FILL / INVAL.
// Optional build macro CACHE_TAG_STATS_EN adds saturating hit/miss counters.
module mp_cache_tag_ctrl
   import mp_cache_tag_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   output logic                   rsp_valid,
   output logic                   rsp_hit,
   output logic                   rsp_victim_valid,
   output logic [TAG_WIDTH-1:0]   rsp_victim_tag,
`ifdef CACHE_TAG_STATS_EN
   output logic [31:0]            stat_hits,
   output logic [31:0]            stat_misses,
`endif
   output logic                   tag_csb0,
   output logic                   tag_web0,
   output logic [INDEX_WIDTH-1:0] tag_addr0,
   output logic [ENTRY_WIDTH-1:0] tag_din0,
   input  logic [ENTRY_WIDTH-1:0] tag_dout0
);

   localparam logic [INDEX_WIDTH-1:0] LAST_SET = {INDEX_WIDTH{1'b1}};

   tag_state_e             state_r;
   logic [INDEX_WIDTH-1:0] cnt_r;
   tag_op_e                op_r;
   logic [TAG_WIDTH-1:0]   tag_r;
   logic [INDEX_WIDTH-1:0] index_r;
   logic                   req_ready_r;
   logic                   rsp_valid_r;

   tag_op_e                req_op_s;
   logic                   req_is_lookup_s;
   logic [INDEX_WIDTH-1:0] req_index_s;
   logic [TAG_WIDTH-1:0]   req_tag_s;
   logic                   accept_s;
   tag_entry_t             dout_entry_s;
   logic                   in_cmp_s;
   logic                   hit_s;
   logic                   unused_offset_s;

   assign req_op_s        = tag_op_e'(req_op);
   assign req_is_lookup_s = (req_op_s == LOOKUP) || (req_op_s == RSVD);
   assign req_index_s     = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_tag_s       = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign unused_offset_s = ^req_addr[OFFSET_WIDTH-1:0];
   assign accept_s        = (state_r == IDLE) && req_valid && req_ready_r;

   assign dout_entry_s    = tag_entry_t'(tag_dout0);
   assign in_cmp_s        = rst_n && (state_r == CMP);
   assign hit_s           = in_cmp_s && entry_hit(dout_entry_s, tag_r);

   // Main FSM: init sweep, request capture and one-cycle response slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= INIT;
         cnt_r       <= {INDEX_WIDTH{1'b0}};
         op_r        <= LOOKUP;
         tag_r       <= {TAG_WIDTH{1'b0}};
         index_r     <= {INDEX_WIDTH{1'b0}};
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         case (state_r)
            INIT: begin
               cnt_r       <= cnt_r + INDEX_WIDTH'(1);
               rsp_valid_r <= 1'b0;
               if (cnt_r == LAST_SET) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
               end else begin
                  req_ready_r <= 1'b0;
               end
            end
            IDLE: begin
               if (accept_s) begin
                  op_r        <= req_is_lookup_s ? LOOKUP : req_op_s;
                  tag_r       <= req_tag_s;
                  index_r     <= req_index_s;
                  req_ready_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= req_is_lookup_s ? CMP : WR;
               end else begin
                  req_ready_r <= 1'b1;
                  rsp_valid_r <= 1'b0;
               end
            end
            CMP, WR: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
            end
            default: begin
               state_r     <= INIT;
               cnt_r       <= {INDEX_WIDTH{1'b0}};
               req_ready_r <= 1'b0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // SRAM port 0 drive; held deselected whenever reset is asserted.
   always_comb begin
      tag_csb0  = 1'b1;
      tag_web0  = 1'b1;
      tag_addr0 = index_r;
      tag_din0  = {ENTRY_WIDTH{1'b0}};
      if (!rst_n) begin
         tag_csb0 = 1'b1;
      end else begin
         case (state_r)
            INIT: begin
               tag_csb0  = 1'b0;
               tag_web0  = 1'b0;
               tag_addr0 = cnt_r;
               tag_din0  = {ENTRY_WIDTH{1'b0}};
            end
            IDLE: begin
               if (accept_s) begin
                  tag_csb0  = 1'b0;
                  tag_web0  = req_is_lookup_s;
                  tag_addr0 = req_index_s;
                  tag_din0  = write_entry(req_op_s, req_tag_s);
               end else begin
                  tag_csb0 = 1'b1;
               end
            end
            CMP: begin
               tag_csb0 = 1'b1;
            end
            WR: begin
               // Deselected: the SRAM still holds and commits the captured write.
               tag_csb0 = 1'b1;
               tag_web0 = 1'b0;
               tag_din0 = write_entry(op_r, tag_r);
            end
            default: begin
               tag_csb0 = 1'b1;
            end
         endcase
      end
   end

   assign req_ready        = req_ready_r && rst_n;
   assign rsp_valid        = rsp_valid_r && rst_n;
   assign rsp_hit          = hit_s;
   assign rsp_victim_valid = in_cmp_s && dout_entry_s.valid;
   assign rsp_victim_tag   = in_cmp_s ? dout_entry_s.tag : {TAG_WIDTH{1'b0}};

`ifdef CACHE_TAG_STATS_EN
   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

   logic [31:0] stat_hits_r;
   logic [31:0] stat_misses_r;

   // Saturating hit/miss counters; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_hits_r   <= 32'd0;
         stat_misses_r <= 32'd0;
      end else if (in_cmp_s) begin
         if (hit_s) begin
            if (stat_hits_r != STAT_MAX) begin
               stat_hits_r <= stat_hits_r + 32'd1;
            end else begin
               stat_hits_r <= stat_hits_r;
            end
         end else begin
            if (stat_misses_r != STAT_MAX) begin
               stat_misses_r <= stat_misses_r + 32'd1;
            end else begin
               stat_misses_r <= stat_misses_r;
            end
         end
      end else begin
         stat_hits_r   <= stat_hits_r;
         stat_misses_r <= stat_misses_r;
      end
   end

   assign stat_hits   = stat_hits_r;
   assign stat_misses = stat_misses_r;
`endif

endmodule

// File: tb/tb_mp_cache_tag_ctrl.sv
// Self-checking bench for mp_cache_tag_ctrl with a behavioural tag SRAM
// and a per-set reference model of the cache tags.
module tb_mp_cache_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_hit;
   logic        rsp_victim_valid;
   logic [22:0] rsp_victim_tag;
   logic        tag_csb0;
   logic        tag_web0;
   logic [3:0]  tag_addr0;
   logic [23:0] tag_din0;
   logic [23:0] tag_dout0;
`ifdef CACHE_TAG_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   int checks = 0;
   int errors = 0;
   int last_wait = 0;

   // Reference model: one valid bit and tag per set, plus lookup statistics.
   logic        ref_valid [16];
   logic [22:0] ref_tag   [16];
   int          ref_hits;
   int          ref_misses;

   always #5 clk = ~clk;

   mp_cache_tag_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_op           (req_op),
      .req_addr         (req_addr),
      .rsp_valid        (rsp_valid),
      .rsp_hit          (rsp_hit),
      .rsp_victim_valid (rsp_victim_valid),
      .rsp_victim_tag   (rsp_victim_tag),
`ifdef CACHE_TAG_STATS_EN
      .stat_hits        (stat_hits),
      .stat_misses      (stat_misses),
`endif
      .tag_csb0         (tag_csb0),
      .tag_web0         (tag_web0),
      .tag_addr0        (tag_addr0),
      .tag_din0         (tag_din0),
      .tag_dout0        (tag_dout0)
   );

   // Single-port SRAM: inputs captured when selected, write committed on the following edge.
   logic [23:0] mem [16];
   logic        mem_seeded = 1'b0;
   logic        web_q      = 1'b1;
   logic [3:0]  addr_q     = 4'd0;
   logic [23:0] din_q      = 24'd0;

   always @(posedge clk) begin
      if (!mem_seeded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 24'($urandom);
         mem_seeded <= 1'b1;
      end else if (!web_q) begin
         mem[addr_q] <= din_q;
      end
      if (!tag_csb0) begin
         web_q  <= tag_web0;
         addr_q <= tag_addr0;
         din_q  <= tag_din0;
      end
   end

   assign tag_dout0 = mem[addr_q];

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = 23'd0;
      end
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   // Hold reset for a number of cycles and check nothing reaches the SRAM.
   task automatic test_reset(input int cycles);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         checks++;
         if (tag_csb0 !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got csb0=%b ready=%b rsp_valid=%b expected 1 0 0",
                     tag_csb0, req_ready, rsp_valid);
         end
      end
      rst_n = 1'b1;
      clear_model();
   endtask

   // Called right after reset release: 16 clearing writes, then ready.
   task automatic test_init_sweep();
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++;
         if (tag_csb0 !== 1'b0 || tag_web0 !== 1'b0 || tag_addr0 !== 4'(i) ||
             tag_din0 !== 24'h0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_write_%0d: got csb0=%b web0=%b addr=%0d din=%h ready=%b expected 0 0 %0d 0 0",
                     i, tag_csb0, tag_web0, tag_addr0, tag_din0, req_ready, i);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (req_ready !== 1'b1 || tag_csb0 !== 1'b1) begin
         errors++;
         $display("FAIL init_done: got ready=%b csb0=%b expected 1 1", req_ready, tag_csb0);
      end
   endtask

   // Issue one request, check SRAM command and response against the model.
   task automatic do_req(input logic [1:0] op, input logic [31:0] addr);
      int          n;
      logic [3:0]  idx;
      logic [22:0] tg;
      logic        is_lk;
      logic        exp_hit;
      logic [23:0] exp_din;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_timeout: got %b expected 1", req_ready);
         return;
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_idle: got %b expected 0", rsp_valid);
      end
      idx     = addr[8:5];
      tg      = addr[31:9];
      is_lk   = (op == 2'd0) || (op == 2'd3);
      exp_hit = is_lk && ref_valid[idx] && (ref_tag[idx] == tg);
      exp_din = (op == 2'd1) ? {1'b1, tg} : 24'h0;

      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      #1;
      checks++;
      if (tag_csb0 !== 1'b0 || tag_web0 !== is_lk || tag_addr0 !== idx ||
          (!is_lk && tag_din0 !== exp_din)) begin
         errors++;
         $display("FAIL sram_cmd op%0d: got csb0=%b web0=%b addr=%0d din=%h expected 0 %b %0d %h",
                  op, tag_csb0, tag_web0, tag_addr0, tag_din0, is_lk, idx, exp_din);
      end
      @(negedge clk);
      req_valid = 1'b0;

      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rsp_valid op%0d: got valid=%b ready=%b expected 1 0", op, rsp_valid, req_ready);
      end
      checks++;
      if (rsp_hit !== exp_hit) begin
         errors++;
         $display("FAIL rsp_hit op%0d addr=%h: got %b expected %b", op, addr, rsp_hit, exp_hit);
      end
      if (is_lk) begin
         checks++;
         if (rsp_victim_valid !== ref_valid[idx] || rsp_victim_tag !== ref_tag[idx]) begin
            errors++;
            $display("FAIL victim addr=%h: got valid=%b tag=%h expected %b %h",
                     addr, rsp_victim_valid, rsp_victim_tag, ref_valid[idx], ref_tag[idx]);
         end
         if (exp_hit) ref_hits++;
         else         ref_misses++;
      end else if (op == 2'd1) begin
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
      end else begin
         ref_valid[idx] = 1'b0;
         ref_tag[idx]   = 23'd0;
      end
   endtask

   task automatic test_directed();
      do_req(2'd0, 32'h1234_5660);
      do_req(2'd1, 32'h1234_5660);
      do_req(2'd0, 32'h1234_5660);
      checks++;
      if (rsp_hit !== 1'b1 || rsp_victim_tag !== 23'h91A2B) begin
         errors++;
         $display("FAIL fill_hit_const: got hit=%b tag=%h expected 1 91a2b", rsp_hit, rsp_victim_tag);
      end
      do_req(2'd0, 32'h0000_0060);
      checks++;
      if (rsp_hit !== 1'b0 || rsp_victim_valid !== 1'b1 || rsp_victim_tag !== 23'h91A2B) begin
         errors++;
         $display("FAIL other_tag_const: got hit=%b vv=%b tag=%h expected 0 1 91a2b",
                  rsp_hit, rsp_victim_valid, rsp_victim_tag);
      end
      do_req(2'd2, 32'h0000_0060);
      do_req(2'd0, 32'h0000_0060);
      checks++;
      if (rsp_victim_valid !== 1'b0) begin
         errors++;
         $display("FAIL inval_const: got vv=%b expected 0", rsp_victim_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_req(2'd1, 32'hFFFF_FFE0);
      for (int k = 0; k < 4; k++) begin
         do_req(2'd0, 32'hFFFF_FFE0);
         checks++;
         if (last_wait !== 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d expected 1", last_wait);
         end
      end
   endtask

   task automatic test_random(input int count);
      logic [22:0] pool [4];
      logic [31:0] a;
      pool[0] = 23'h000000;
      pool[1] = 23'h091A2B;
      pool[2] = 23'h7FFFFF;
      pool[3] = 23'h000001;
      for (int k = 0; k < count; k++) begin
         a = {pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
         do_req(2'($urandom_range(0, 3)), a);
      end
   endtask

   // Reset pulse during the WR cycle of a FILL: response dropped, sweep reruns.
   task automatic test_reset_mid_op();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_op    = 2'd1;
      req_addr  = 32'h1234_5660;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || tag_csb0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_drop: got rsp_valid=%b csb0=%b expected 0 1", rsp_valid, tag_csb0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      test_init_sweep();
      do_req(2'd0, 32'h1234_5660);
      checks++;
      if (rsp_hit !== 1'b0 || rsp_victim_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_miss: got hit=%b vv=%b expected 0 0", rsp_hit, rsp_victim_valid);
      end
   endtask

`ifdef CACHE_TAG_STATS_EN
   task automatic test_stats();
      test_reset(2);
      test_init_sweep();
      do_req(2'd1, 32'h1234_5660);
      repeat (3) do_req(2'd0, 32'h1234_5660);
      repeat (2) do_req(2'd0, 32'h0000_0080);
      @(negedge clk);
      checks++;
      if (stat_hits !== 32'(ref_hits) || stat_misses !== 32'(ref_misses) ||
          stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
         errors++;
         $display("FAIL stats_count: got %0d/%0d expected %0d/%0d", stat_hits, stat_misses, ref_hits, ref_misses);
      end
      test_reset(1);
      checks++;
      if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
         errors++;
         $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_hits, stat_misses);
      end
      test_init_sweep();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_addr  = 32'd0;
      clear_model();
      test_reset(3);
      test_init_sweep();
      test_directed();
      test_back_to_back();
      test_random(60);
      test_reset_mid_op();
      test_random(30);
`ifdef CACHE_TAG_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
